// File: rtl/cmd_arb.sv
// cmd_arb: command arbiter/sequencer sharing cmd_proc between the UART and tour command sources.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_UART/cmd_rdy_UART : UART command word and its pending level; clr_UART pulses when consumed
//   tour_cmd/tour_rdy     : tour command word and pending level; tour_last marks the final move
//   tour_ack              : pulse, tour move completed
//   cmd/cmd_rdy           : registered command to cmd_proc; clr_cmd_rdy accepts, send_resp completes
//   resp/trmt/tx_done     : response byte, transmit pulse, transmit-done pulse
//   tour_busy/abort       : tour mode level, abort pulse
//   Define CMD_ARB_WDOG_EN to include the WAIT watchdog (0xE0 abort).
module cmd_arb #(
    parameter int FAST_SIM = 1,
    parameter int WDOG_W   = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_UART,
    input  logic [15:0] tour_cmd,
    input  logic        tour_rdy,
    input  logic        tour_last,
    output logic        tour_ack,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        trmt,
    input  logic        tx_done,
    output logic        tour_busy,
    output logic        abort
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [WDOG_W-1:0] WDOG_T = (FAST_SIM != 0) ? WDOG_W'(4095) : {WDOG_W{1'b1}};
    state_t      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [7:0]  resp_q, resp_d;
    logic        cmd_rdy_q, cmd_rdy_d, trmt_q, trmt_d, tour_ack_q, tour_ack_d;
    logic        clr_uart_q, clr_uart_d, abort_q, abort_d, src_q, src_d, last_q, last_d;
    logic        tour_mode_q, tour_mode_d, stop_pend_q, stop_pend_d;
    logic        uart_new, tour_take, stop_req, stop_now, done, wdog_exp;
    // cmd_rdy_UART stays high for a cycle after clr_UART while the wrapper clears it
    assign uart_new  = cmd_rdy_UART && !clr_uart_q;
    // in tour mode UART commands are swallowed, except that a waiting tour move wins in IDLE
    assign tour_take = tour_mode_q && uart_new && !(state_q == IDLE && tour_rdy);
    assign stop_req  = tour_take && cmd_UART[15:12] == 4'hF;
    // a STOP seen during RESP is held until the current byte has gone out
    assign stop_now  = (stop_req && (state_q != RESP || tx_done)) || (state_q == RESP && tx_done && stop_pend_q);
    assign done      = (state_q == ISSUE || state_q == WAIT) && send_resp;
`ifdef CMD_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    assign wdog_d   = (state_q == WAIT) ? wdog_q + 1'b1 : '0;
    assign wdog_exp = state_q == WAIT && wdog_q == WDOG_T && !send_resp;
    always_ff @(posedge clk)
        wdog_q <= rst ? '0 : wdog_d;
`else
    logic [WDOG_W-1:0] unused_wdog_t;
    assign unused_wdog_t = WDOG_T;
    assign wdog_exp      = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        resp_d      = resp_q;
        trmt_d      = 1'b0;
        tour_ack_d  = 1'b0;
        clr_uart_d  = tour_take;
        abort_d     = 1'b0;
        src_d       = src_q;
        last_d      = last_q;
        tour_mode_d = tour_mode_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            IDLE: begin
                if (!tour_mode_q && uart_new) begin
                    cmd_d      = cmd_UART;
                    cmd_rdy_d  = 1'b1;
                    clr_uart_d = 1'b1;
                    src_d      = 1'b0;
                    state_d    = ISSUE;
                end else if (tour_rdy) begin
                    cmd_d       = tour_cmd;
                    last_d      = tour_last;
                    cmd_rdy_d   = 1'b1;
                    src_d       = 1'b1;
                    tour_mode_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            RESP: state_d = tx_done ? IDLE : RESP;
            default: ;
        endcase
        // send_resp in ISSUE acts as accept plus completion
        if (done) begin
            resp_d      = (src_q && !last_q) ? 8'h5A : 8'hA5;
            trmt_d      = 1'b1;
            tour_ack_d  = src_q;
            cmd_rdy_d   = 1'b0;
            tour_mode_d = tour_mode_q && !(src_q && last_q);
            state_d     = RESP;
        end
        if (stop_now || wdog_exp) begin
            abort_d     = 1'b1;
            tour_mode_d = 1'b0;
            cmd_rdy_d   = 1'b0;
            resp_d      = stop_now ? 8'hE1 : 8'hE0;
            trmt_d      = 1'b1;
            tour_ack_d  = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = RESP;
        end else if (stop_req) begin
            stop_pend_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            resp_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            trmt_q      <= 1'b0;
            tour_ack_q  <= 1'b0;
            clr_uart_q  <= 1'b0;
            abort_q     <= 1'b0;
            src_q       <= 1'b0;
            last_q      <= 1'b0;
            tour_mode_q <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            cmd_rdy_q   <= cmd_rdy_d;
            trmt_q      <= trmt_d;
            tour_ack_q  <= tour_ack_d;
            clr_uart_q  <= clr_uart_d;
            abort_q     <= abort_d;
            src_q       <= src_d;
            last_q      <= last_d;
            tour_mode_q <= tour_mode_d;
            stop_pend_q <= stop_pend_d;
        end
    end
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp      = resp_q;
    assign trmt      = trmt_q;
    assign tour_ack  = tour_ack_q;
    assign clr_UART  = clr_uart_q;
    assign abort     = abort_q;
    assign tour_busy = tour_mode_q;
endmodule
